ctrl_io_dr_sequencer: RTL
=========================

// Module: ctrl_io_dr_sequencer
// PURPOSE
//  Off-fabric controller wired to the ctrl_IO tile's external BEL pins (A_*); the stage that feeds and consumes the tile.
//  Runs the dual-rail precharge/evaluate cycle: drives A_prech2, encodes host bits onto A_O_top_0_t/f, and decodes A_I_top_0_t/f into host bits.
//  Checks every fabric codeword, merges the fabric fault flag A_F_ctrl, and returns the fault state on A_DR_fault.
// PARAMETERS
//  PRECH_CYCLES  1  precharge phase length in UserCLK cycles (>=1)
//  EVAL_CYCLES   2  evaluate phase length in UserCLK cycles (>=1)
//  FAULT_STICKY  1  1: fault latches until fault_clr; 0: one-cycle fault pulse, sequencing continues
// PORTS
//  UserCLK      in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  en           in   1  enable sequencing
//  tx_data      in   1  host bit to send
//  tx_valid     in   1  tx_data valid
//  tx_ready     out  1  token accepted when tx_valid&tx_ready
//  rx_data      out  1  decoded fabric bit
//  rx_valid     out  1  one-cycle strobe, rx_data valid
//  fault_clr    in   1  clear sticky fault, return to IDLE
//  fault        out  1  fault flag
//  fault_code   out  3  001 prech-violation, 010 both-rails, 011 incomplete, 100 fabric F_ctrl
//  A_O_top_0_t  out  1  dual-rail true rail into fabric
//  A_O_top_0_f  out  1  dual-rail false rail into fabric
//  A_prech2     out  1  1 = precharge phase
//  A_DR_fault   out  1  fault indication into fabric (= fault)
//  A_I_top_0_t  in   1  dual-rail true rail from fabric
//  A_I_top_0_f  in   1  dual-rail false rail from fabric
//  A_T_top      in   1  1 = fabric output disabled; no rx decode or rail checks
//  A_F_ctrl     in   1  fabric-reported fault
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, A_prech2=1, O rails 00, tx_ready=0, rx_valid=0, rx_data=0, fault=0, fault_code=000, A_DR_fault=0.
//  Registers: all outputs registered except tx_ready, which is decoded from state/cnt/en only and never from tx_valid.
//  Phase counter cnt: resets to 0 on every state change; wraps at PRECH_CYCLES-1 or EVAL_CYCLES-1.
//  FSM states: IDLE, PRECH, EVAL, ALARM.
//   IDLE: prech2=1, rails 00. en=1 -> PRECH.
//   PRECH: prech2=1, rails 00.
//    - tx_ready=1 only when cnt==PRECH_CYCLES-1 and en=1.
//    - On accept, latch tx_data plus a token flag. With no accept, clear the token flag (null token).
//    - At end of phase -> EVAL. en=0 at any PRECH cycle -> IDLE next cycle, no accept.
//   EVAL: prech2=0.
//    - Rails = {bit,~bit} when the token flag is set, else 00, held for the whole phase.
//    - At end of phase: en=1 -> PRECH; en=0 -> IDLE. A started EVAL always completes.
//   ALARM: prech2=1, rails 00, tx_ready=0. fault_clr=1 -> IDLE and clears fault/fault_code.
//  Latency: accept in cycle t puts rails valid in cycles t+1..t+EVAL_CYCLES; rx_valid rises in cycle t+EVAL_CYCLES+1.
//  Checks (skipped while A_T_top=1; A_F_ctrl is always checked):
//   - F_ctrl=1 in any non-IDLE cycle -> 100.
//   - Last PRECH cycle with I rails !=00 -> 001.
//   - Last EVAL cycle, I=11 -> 010.
//   - Last EVAL cycle, I=00 with token set -> 011.
//   - Last EVAL cycle, I=10/01 -> rx_data=1/0, rx_valid=1. The null token decodes too if rails are valid.
//  Fault handling:
//   - Simultaneous detections: priority 100 > 010 > 001 > 011. Decode is suppressed on the cycle a fault is detected.
//   - fault, fault_code and A_DR_fault update the cycle after detection.
//   - FAULT_STICKY=1: go to ALARM. Further faults do not overwrite the first code until fault_clr.
//   - FAULT_STICKY=0: fault/A_DR_fault pulse one cycle, code holds until the next fault, FSM proceeds normally.
//  fault_clr outside ALARM is ignored. rst overrides everything, including mid-EVAL, and sets reset values next cycle.
// TESTING
//  1 P=1,E=2, en=1, tx_data=1 valid, fabric model I=O delayed 1 cycle -> prech2 1,0,0,1,...; rx_data=1, rx_valid at t+3; fault=0.
//  2 Same, fabric returns 11 at end of EVAL -> fault=1, code=010, A_DR_fault=1; ALARM, rails 00, tx_ready=0 until fault_clr; then IDLE.
//  3 Fabric holds I=10 through last PRECH cycle -> code 001; with FAULT_STICKY=0, fault pulses 1 cycle and the next token still decodes.
//  4 F_ctrl=1 on the same cycle as I=11 at end of EVAL -> code 100; later I=00 faults do not change the code.
//  5 T_top=1, I=00 throughout, token 0 sent -> no fault, no rx_valid; tx_ready keeps pulsing once per round.
//  6 rst mid-EVAL -> next cycle all reset values. Separately: en dropped mid-EVAL -> EVAL finishes, rx_valid once, then IDLE with prech2=1.

Source files
------------

// File: rtl/ctrl_io_dr_sequencer.sv
// ctrl_IO dual-rail sequencer: runs precharge/evaluate on the tile's A_* pins,
// encodes and decodes host bits, and reports codeword and fabric faults.
//
// state | meaning
// IDLE  | precharged, waiting for en
// PRECH | precharge phase; host token accepted on its last cycle
// EVAL  | evaluate phase; rails carry the token, fabric rails checked on last cycle
// ALARM | sticky fault held with rails precharged until fault_clr
module ctrl_io_dr_sequencer #(
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 2,
    parameter int FAULT_STICKY = 1
) (
    input  logic       UserCLK,
    input  logic       rst,
    input  logic       en,
    input  logic       tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_data,
    output logic       rx_valid,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       A_O_top_0_t,
    output logic       A_O_top_0_f,
    output logic       A_prech2,
    output logic       A_DR_fault,
    input  logic       A_I_top_0_t,
    input  logic       A_I_top_0_f,
    input  logic       A_T_top,
    input  logic       A_F_ctrl
);

    localparam int MAXC = (PRECH_CYCLES > EVAL_CYCLES) ? PRECH_CYCLES : EVAL_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PRECH_LAST = CW'(PRECH_CYCLES - 1);
    localparam logic [CW-1:0] EVAL_LAST  = CW'(EVAL_CYCLES - 1);

    localparam logic [2:0] FC_NONE  = 3'b000;
    localparam logic [2:0] FC_PRECH = 3'b001;
    localparam logic [2:0] FC_BOTH  = 3'b010;
    localparam logic [2:0] FC_INCMP = 3'b011;
    localparam logic [2:0] FC_FCTRL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRECH = 2'd1,
        S_EVAL  = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_tok;
    logic            r_bit;
    logic            r_prech2;
    logic            r_o_t;
    logic            r_o_f;
    logic            r_rx_data;
    logic            r_rx_valid;
    logic            r_fault;
    logic [2:0]      r_code;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic            w_prech_last;
    logic            w_eval_last;
    logic            w_accept;
    logic            w_tok_nx;
    logic            w_bit_nx;
    logic            w_prech2_nx;
    logic [1:0]      w_rails_nx;
    logic [1:0]      w_i;
    logic            w_chk;
    logic            w_det_f;
    logic            w_det_p;
    logic            w_det_b;
    logic            w_det_i;
    logic            w_det_any;
    logic [2:0]      w_code_det;
    logic            w_decode;

    assign w_prech_last = (r_state == S_PRECH) && (r_cnt == PRECH_LAST);
    assign w_eval_last  = (r_state == S_EVAL) && (r_cnt == EVAL_LAST);
    assign tx_ready     = w_prech_last && en;
    assign w_accept     = tx_ready && tx_valid;
    assign w_i          = {A_I_top_0_t, A_I_top_0_f};

    // Next-state and phase counter
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nx = S_PRECH;
            S_PRECH: begin
                if (!en)               w_state_nx = S_IDLE;
                else if (w_prech_last) w_state_nx = S_EVAL;
            end
            S_EVAL:  if (w_eval_last) w_state_nx = en ? S_PRECH : S_IDLE;
            S_ALARM: if (fault_clr) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if ((FAULT_STICKY != 0) && w_det_any && (r_state != S_ALARM))
            w_state_nx = S_ALARM;

        w_cnt_nx = '0;
        if ((w_state_nx == r_state) &&
            (((r_state == S_PRECH) && !w_prech_last) || ((r_state == S_EVAL) && !w_eval_last)))
            w_cnt_nx = r_cnt + CW'(1);
    end

    // Checks, decode and next values of the registered outputs
    always_comb begin
        w_chk   = !A_T_top;
        w_det_f = A_F_ctrl && (r_state != S_IDLE);
        w_det_p = w_chk && w_prech_last && (w_i != 2'b00);
        w_det_b = w_chk && w_eval_last && (w_i == 2'b11);
        w_det_i = w_chk && w_eval_last && (w_i == 2'b00) && r_tok;
        w_det_any = w_det_f || w_det_p || w_det_b || w_det_i;

        w_code_det = FC_NONE;
        if (w_det_f)      w_code_det = FC_FCTRL;
        else if (w_det_b) w_code_det = FC_BOTH;
        else if (w_det_p) w_code_det = FC_PRECH;
        else if (w_det_i) w_code_det = FC_INCMP;

        w_decode = w_chk && w_eval_last && (w_i[1] ^ w_i[0]) && !w_det_any;

        // A PRECH that ends without an accept carries a null token into EVAL
        w_tok_nx = w_prech_last ? w_accept : r_tok;
        w_bit_nx = w_accept ? tx_data : r_bit;

        w_prech2_nx = (w_state_nx != S_EVAL);
        w_rails_nx  = 2'b00;
        if ((w_state_nx == S_EVAL) && w_tok_nx)
            w_rails_nx = {w_bit_nx, ~w_bit_nx};
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tok      <= 1'b0;
            r_bit      <= 1'b0;
            r_prech2   <= 1'b1;
            r_o_t      <= 1'b0;
            r_o_f      <= 1'b0;
            r_rx_data  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_code     <= FC_NONE;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_tok      <= w_tok_nx;
            r_bit      <= w_bit_nx;
            r_prech2   <= w_prech2_nx;
            r_o_t      <= w_rails_nx[1];
            r_o_f      <= w_rails_nx[0];
            r_rx_valid <= w_decode;
            if (w_decode)
                r_rx_data <= A_I_top_0_t;
            if (FAULT_STICKY != 0) begin
                // First code wins; only fault_clr in ALARM releases it
                if (r_state == S_ALARM) begin
                    if (fault_clr) begin
                        r_fault <= 1'b0;
                        r_code  <= FC_NONE;
                    end
                end else if (w_det_any) begin
                    r_fault <= 1'b1;
                    r_code  <= w_code_det;
                end
            end else begin
                r_fault <= w_det_any;
                if (w_det_any)
                    r_code <= w_code_det;
            end
        end
    end

    assign A_prech2    = r_prech2;
    assign A_O_top_0_t = r_o_t;
    assign A_O_top_0_f = r_o_f;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign A_DR_fault  = r_fault;

endmodule
